// File: rtl/isqrt_seq.sv
// Sequential unsigned integer square root, one root bit per clock.
// Radix-4 restoring recurrence behind valid/ready handshakes.
module isqrt_seq #(
    parameter int INPUTWIDTH = 42,
    localparam int N = (INPUTWIDTH + 1) / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUTWIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          root_out,
    output logic [N:0]            rem_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  rad_q, rad_d;
    logic [N-1:0]    root_q, root_d;
    logic [N+1:0]    rem_q, rem_d;
    logic [N-1:0]    res_root_q, res_root_d;
    logic [N:0]      res_rem_q, res_rem_d;

    logic [N+3:0]    trial, test;
    logic            fits;

    // Partial remainder with the next radicand digit pair appended
    always_comb begin
        trial = {rem_q, rad_q[2*N-1 -: 2]};
        test  = (N+4)'({root_q, 2'b01});
        fits  = (trial >= test);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rad_d      = rad_q;
        root_d     = root_q;
        rem_d      = rem_q;
        res_root_d = res_root_q;
        res_rem_d  = res_rem_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rad_d                   = '0;
                    rad_d[INPUTWIDTH-1:0]   = data_in;
                    root_d                  = '0;
                    rem_d                   = '0;
                    cnt_d                   = LAST;
                    state_d                 = CALC;
                end
            end
            CALC: begin
                rad_d     = rad_q << 2;
                root_d    = root_q << 1;
                root_d[0] = fits;
                rem_d     = (N+2)'(fits ? trial - test : trial);
                if (cnt_q == '0) begin
                    res_root_d = root_d;
                    res_rem_d  = rem_d[N:0];
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rad_q      <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            res_root_q <= '0;
            res_rem_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rad_q      <= rad_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
            res_root_q <= res_root_d;
            res_rem_q  <= res_rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign root_out  = res_root_q;
    assign rem_out   = res_rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: directed cases at width 42, random
// operands at width 41 against a real-valued sqrt model.
module tb_isqrt_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [41:0] a_data;
    logic [20:0] a_root;
    logic [21:0] a_rem;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [40:0] b_data;
    logic [20:0] b_root;
    logic [21:0] b_rem;

    isqrt_seq #(.INPUTWIDTH(42)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .root_out(a_root), .rem_out(a_rem), .busy(a_busy)
    );

    isqrt_seq #(.INPUTWIDTH(41)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .root_out(b_root), .rem_out(b_rem), .busy(b_busy)
    );

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt_ref(input longint x);
        longint r;
        r = longint'($sqrt(real'(x)));
        while (r > 0 && r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic send_a(input logic [41:0] x);
        @(negedge clk);
        chk("a_in_ready_idle", a_in_ready, 1);
        a_data = x;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_data = '0;
    endtask

    task automatic wait_a(input string tag);
        int lat;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 21);
    endtask

    task automatic pop_a();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
    endtask

    task automatic run_a(input string tag, input logic [41:0] x,
                         input longint er, input longint em);
        send_a(x);
        wait_a(tag);
        chk({tag, "_root"}, a_root, er);
        chk({tag, "_rem"}, a_rem, em);
        chk({tag, "_busy"}, a_busy, 1);
        chk({tag, "_inrdy_done"}, a_in_ready, 0);
        pop_a();
        chk({tag, "_ov_after"}, a_out_valid, 0);
        chk({tag, "_inrdy_after"}, a_in_ready, 1);
        chk({tag, "_root_hold"}, a_root, er);
    endtask

    task automatic run_b(input string tag, input logic [40:0] x,
                         input longint er, input longint em);
        int lat;
        @(negedge clk);
        b_data = x;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 21);
        chk({tag, "_root"}, b_root, er);
        chk({tag, "_rem"}, b_rem, em);
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        chk({tag, "_ov_after"}, b_out_valid, 0);
    endtask

    initial begin
        logic [63:0] raw;
        longint x, r;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_data = '0;
        #12;
        chk("rst_a_inrdy", a_in_ready, 1);
        chk("rst_a_ov", a_out_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_root", a_root, 0);
        chk("rst_a_rem", a_rem, 0);
        chk("rst_b_inrdy", b_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_a("zero", 42'd0, 0, 0);
        run_a("max42", {42{1'b1}}, 2097151, 4194302);
        run_a("k1000", 42'd1000000, 1000, 0);
        run_a("k1000r", 42'd1002000, 1000, 2000);
        run_a("k1001", 42'd1002001, 1001, 0);

        // Backpressure with a stray input pulse while holding a result
        send_a(42'd1002000);
        wait_a("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_in_valid = (i == 2);
            a_data = (i == 2) ? 42'd4 : 42'd0;
            @(posedge clk);
            #1;
            chk("bp_ov", a_out_valid, 1);
            chk("bp_root", a_root, 1000);
            chk("bp_rem", a_rem, 2000);
            chk("bp_inrdy", a_in_ready, 0);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        pop_a();
        chk("bp_rel_busy", a_busy, 0);
        chk("bp_rel_inrdy", a_in_ready, 1);
        chk("bp_rel_ov", a_out_valid, 0);
        @(posedge clk);
        #1;
        chk("bp_no_accept", a_busy, 0);

        // Asynchronous reset in the middle of a calculation
        send_a(42'd123456789);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inrdy", a_in_ready, 1);
        chk("mid_rst_ov", a_out_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_root", a_root, 0);
        chk("mid_rst_rem", a_rem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a("after_rst", 42'd49, 7, 0);

        x = (64'd1 << 41) - 1;
        run_b("max41", x[40:0], 1482910, x - 64'd1482910 * 64'd1482910);

        for (int i = 0; i < 500; i++) begin
            raw = {$urandom(), $urandom()};
            x = longint'({23'd0, raw[40:0]} >> $urandom_range(0, 40));
            r = isqrt_ref(x);
            run_b("rnd", x[40:0], r, x - r * r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
